// File: rtl/ifetch_line_requester_if.sv
// Sysbus connection between the instruction-fetch line requester (master)
// and the system bus (slave): one request channel, one response channel.
interface ifetch_line_requester_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) ();

  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp
  );

endinterface

// File: rtl/ifetch_line_requester.sv
// Fetches one 64-byte instruction line over Sysbus and hands each returned
// beat, with its 1-based beat number, to the downstream fetcher.
module ifetch_line_requester #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8,
  localparam int CNT_W         = $clog2(LINE_BEATS) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      fetch_start,
  input  logic [63:0]               start_addr,
  ifetch_line_requester_if.master   bus,
  output logic [BUS_DATA_WIDTH-1:0] data,
  output logic [CNT_W-1:0]          count,
  output logic                      fetch_en,
  output logic                      busy,
  output logic                      line_done
);

  localparam int         OFS_W         = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 8);
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e                    state_q, state_d;
  logic [63:0]               addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      fetch_en_q, fetch_en_d;
  logic                      line_done_q, line_done_d;

  // count_q doubles as the beat counter: it holds the number of beats
  // accepted so far, so the beat being accepted gets count_q + 1.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    count_d     = count_q;
    fetch_en_d  = 1'b0;
    line_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_start) begin
          addr_d  = {start_addr[63:OFS_W], OFS_W'(0)};
          count_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.bus_reqack) state_d = RESP;
      end
      RESP: begin
        if (bus.bus_respcyc) begin
          data_d     = bus.bus_resp;
          count_d    = count_q + 1'b1;
          fetch_en_d = 1'b1;
          if (count_q == LAST_IDX) begin
            line_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next-state value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      fetch_en_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      fetch_en_q  <= fetch_en_d;
      line_done_q <= line_done_d;
    end
  end

  // Request fields come straight from the captured address so they stay
  // stable for the whole time bus_reqcyc is high.
  assign bus.bus_reqcyc  = (state_q == REQ);
  assign bus.bus_req     = BUS_DATA_WIDTH'(addr_q);
  assign bus.bus_reqtag  = BUS_TAG_WIDTH'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00});
  assign bus.bus_respack = (state_q == RESP) && bus.bus_respcyc;

  assign data      = data_q;
  assign count     = count_q;
  assign fetch_en  = fetch_en_q;
  assign line_done = line_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ifetch_line_requester.sv
// Self-checking bench for ifetch_line_requester: directed sequences, a cycle
// table for gapped/stray responses, and randomized lines against a scoreboard.
module tb_ifetch_line_requester;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam logic [TW-1:0] EXP_TAG = 13'h1100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic [63:0] start_addr = '0;
  logic [63:0] data;
  logic [3:0]  count;
  logic        fetch_en, busy, line_done;

  always #5 clk = ~clk;

  ifetch_line_requester_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();

  ifetch_line_requester #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .LINE_BEATS(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_start (fetch_start),
    .start_addr  (start_addr),
    .bus         (bif.master),
    .data        (data),
    .count       (count),
    .fetch_en    (fetch_en),
    .busy        (busy),
    .line_done   (line_done)
  );

  typedef struct {
    logic [63:0] d;
    logic [3:0]  c;
    logic        ld;
  } beat_t;

  typedef struct {
    logic        respcyc;
    logic [63:0] resp;
    logic        respack;
    logic        fe;
    logic [3:0]  cnt;
    logic [63:0] dat;
    logic        ld;
    logic        bsy;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vtab[15];
  int    n_vec = 0;
  int    n_miss = 0;
  int    n_pulses = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every fetch_en pulse must match the oldest beat the bus sent.
  beat_t mon_e;
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      if (fetch_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch_en", 64'(fetch_en), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", data, mon_e.d);
          check("beat_count", 64'(count), 64'(mon_e.c));
          check("beat_line_done", 64'(line_done), 64'(mon_e.ld));
          n_pulses++;
        end
      end else begin
        check("line_done_without_fetch_en", 64'(line_done), 64'(0));
      end
    end
  end

  // Called just after a rising edge with the DUT in IDLE; returns in REQ.
  task automatic do_fetch(input logic [63:0] addr);
    fetch_start = 1'b1;
    start_addr  = addr;
    @(posedge clk); #1;
    fetch_start = 1'b0;
  endtask

  task automatic req_phase(input logic [63:0] exp_addr, input int delay);
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) bif.bus_reqack = 1'b1;
      @(negedge clk);
      check("req_reqcyc", 64'(bif.bus_reqcyc), 64'(1));
      check("req_addr", bif.bus_req, exp_addr);
      check("req_tag", 64'(bif.bus_reqtag), 64'(EXP_TAG));
      check("req_count_cleared", 64'(count), 64'(0));
      check("req_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
    end
    bif.bus_reqack = 1'b0;
  endtask

  // Beat i carries base*(i+1); gaps holds a 2-bit idle count before each beat.
  task automatic resp_phase(input logic [63:0] base, input logic [15:0] gaps,
                            input bit inject, input logic [63:0] inj_addr,
                            input bit chain, input logic [63:0] next_addr,
                            input int nbeats);
    bit first = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      for (int g = 0; g < int'(gaps[2*i +: 2]); g++) begin
        bif.bus_respcyc = 1'b0;
        @(negedge clk);
        if (first) check("reqcyc_dropped", 64'(bif.bus_reqcyc), 64'(0));
        first = 1'b0;
        check("gap_respack", 64'(bif.bus_respack), 64'(0));
        check("gap_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
      end
      bif.bus_respcyc = 1'b1;
      bif.bus_resp    = base * 64'(i + 1);
      exp_q.push_back('{base * 64'(i + 1), 4'(i + 1), (i == 7)});
      if (inject && i == 2) begin
        fetch_start = 1'b1;
        start_addr  = inj_addr;
      end
      @(negedge clk);
      if (first) check("reqcyc_dropped", 64'(bif.bus_reqcyc), 64'(0));
      first = 1'b0;
      check("beat_respack", 64'(bif.bus_respack), 64'(1));
      @(posedge clk); #1;
      fetch_start = 1'b0;
    end
    bif.bus_respcyc = 1'b0;
    if (nbeats == 8) begin
      if (chain) begin
        fetch_start = 1'b1;
        start_addr  = next_addr;
      end
      @(negedge clk);
      check("done_cycle_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      fetch_start = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] addr, next_addr, base;
    bit          chained, chain;
    int          p0;

    // Gapped line (beats 3 and 6 preceded by 2 idle cycles) then a stray beat in IDLE.
    vtab[0]  = '{1'b1, 64'h11, 1'b1, 1'b0, 4'd0, 64'h88, 1'b0, 1'b1};
    vtab[1]  = '{1'b1, 64'h22, 1'b1, 1'b1, 4'd1, 64'h11, 1'b0, 1'b1};
    vtab[2]  = '{1'b0, 64'h00, 1'b0, 1'b1, 4'd2, 64'h22, 1'b0, 1'b1};
    vtab[3]  = '{1'b0, 64'h00, 1'b0, 1'b0, 4'd2, 64'h22, 1'b0, 1'b1};
    vtab[4]  = '{1'b1, 64'h33, 1'b1, 1'b0, 4'd2, 64'h22, 1'b0, 1'b1};
    vtab[5]  = '{1'b1, 64'h44, 1'b1, 1'b1, 4'd3, 64'h33, 1'b0, 1'b1};
    vtab[6]  = '{1'b1, 64'h55, 1'b1, 1'b1, 4'd4, 64'h44, 1'b0, 1'b1};
    vtab[7]  = '{1'b0, 64'h00, 1'b0, 1'b1, 4'd5, 64'h55, 1'b0, 1'b1};
    vtab[8]  = '{1'b0, 64'h00, 1'b0, 1'b0, 4'd5, 64'h55, 1'b0, 1'b1};
    vtab[9]  = '{1'b1, 64'h66, 1'b1, 1'b0, 4'd5, 64'h55, 1'b0, 1'b1};
    vtab[10] = '{1'b1, 64'h77, 1'b1, 1'b1, 4'd6, 64'h66, 1'b0, 1'b1};
    vtab[11] = '{1'b1, 64'h88, 1'b1, 1'b1, 4'd7, 64'h77, 1'b0, 1'b1};
    vtab[12] = '{1'b0, 64'h00, 1'b0, 1'b1, 4'd8, 64'h88, 1'b1, 1'b0};
    vtab[13] = '{1'b1, 64'h99, 1'b0, 1'b0, 4'd8, 64'h88, 1'b0, 1'b0};
    vtab[14] = '{1'b0, 64'h00, 1'b0, 1'b0, 4'd8, 64'h88, 1'b0, 1'b0};

    bif.bus_reqack  = 1'b0;
    bif.bus_respcyc = 1'b0;
    bif.bus_resp    = '0;

    // Reset state
    #12;
    check("rst_reqcyc", 64'(bif.bus_reqcyc), 64'(0));
    check("rst_respack", 64'(bif.bus_respack), 64'(0));
    check("rst_fetch_en", 64'(fetch_en), 64'(0));
    check("rst_line_done", 64'(line_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_data", data, 64'(0));
    check("rst_count", 64'(count), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Basic line
    p0 = n_pulses;
    do_fetch(64'h1000_0044);
    req_phase(64'h1000_0040, 2);
    resp_phase(64'h11, 16'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8);
    @(negedge clk);
    check("basic_busy_after", 64'(busy), 64'(0));
    check("basic_pulses", 64'(n_pulses - p0), 64'(8));
    @(posedge clk); #1;

    // Gapped response and stray response, cycle by cycle
    mon_en = 1'b0;
    do_fetch(64'h4000);
    req_phase(64'h4000, 0);
    for (int r = 0; r < 15; r++) begin
      bif.bus_respcyc = vtab[r].respcyc;
      bif.bus_resp    = vtab[r].resp;
      @(negedge clk);
      check($sformatf("tab%0d_respack", r), 64'(bif.bus_respack), 64'(vtab[r].respack));
      check($sformatf("tab%0d_fetch_en", r), 64'(fetch_en), 64'(vtab[r].fe));
      check($sformatf("tab%0d_count", r), 64'(count), 64'(vtab[r].cnt));
      check($sformatf("tab%0d_data", r), data, vtab[r].dat);
      check($sformatf("tab%0d_line_done", r), 64'(line_done), 64'(vtab[r].ld));
      check($sformatf("tab%0d_busy", r), 64'(busy), 64'(vtab[r].bsy));
      check($sformatf("tab%0d_reqcyc", r), 64'(bif.bus_reqcyc), 64'(0));
      @(posedge clk); #1;
    end
    bif.bus_respcyc = 1'b0;
    mon_en = 1'b1;

    // Delayed ack: six request cycles with a stable address
    do_fetch(64'h5555_5555_0000_0abc);
    req_phase(64'h5555_5555_0000_0a80, 5);
    resp_phase(64'h0123_4567_89ab_cdef, 16'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8);

    // Busy collision: ignored mid-line start, accepted start on line_done cycle
    do_fetch(64'h6000);
    req_phase(64'h6000, 1);
    resp_phase(64'h0a0a, 16'h0, 1'b1, 64'h2000, 1'b1, 64'h3008, 8);
    req_phase(64'h3000, 0);
    resp_phase(64'h0b0b, 16'h0, 1'b0, 64'h0, 1'b0, 64'h0, 8);

    // Randomized lines against the scoreboard
    chained = 1'b0;
    addr    = '0;
    for (int k = 0; k < 40; k++) begin
      if (!chained) begin
        if ($urandom_range(0, 1) == 1) begin
          bif.bus_respcyc = 1'b1;
          bif.bus_resp    = {$urandom, $urandom};
          @(negedge clk);
          check("idle_stray_respack", 64'(bif.bus_respack), 64'(0));
          check("idle_count_held", 64'(count), 64'(8));
          @(posedge clk); #1;
          bif.bus_respcyc = 1'b0;
        end
        addr = {$urandom, $urandom};
        do_fetch(addr);
      end
      req_phase(addr & ~64'h3f, int'($urandom_range(0, 4)));
      base      = {$urandom, $urandom};
      next_addr = {$urandom, $urandom};
      chain     = (k != 39) && ($urandom_range(0, 2) == 0);
      resp_phase(base, 16'($urandom), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 chain, next_addr, 8);
      chained = chain;
      addr    = next_addr;
    end

    // Mid-line reset after beat 4
    do_fetch(64'h7000);
    req_phase(64'h7000, 0);
    resp_phase(64'h1234, 16'h0, 1'b0, 64'h0, 1'b0, 64'h0, 4);
    @(negedge clk);
    #2;
    mon_en          = 1'b0;
    reset_n         = 1'b0;
    bif.bus_respcyc = 1'b1;
    #1;
    check("midrst_reqcyc", 64'(bif.bus_reqcyc), 64'(0));
    check("midrst_respack", 64'(bif.bus_respack), 64'(0));
    check("midrst_fetch_en", 64'(fetch_en), 64'(0));
    check("midrst_line_done", 64'(line_done), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_data", data, 64'(0));
    check("midrst_count", 64'(count), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("postrst_respack", 64'(bif.bus_respack), 64'(0));
      check("postrst_fetch_en", 64'(fetch_en), 64'(0));
      check("postrst_count", 64'(count), 64'(0));
      @(posedge clk); #1;
    end
    bif.bus_respcyc = 1'b0;

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ifetch_line_requester.md
Name: ifetch_line_requester

Overview:
- Bus-side initiator for instruction fetch.
- On a fetch request it issues one Sysbus read for the 64-byte line containing the requested address, accepts the 8 returned 64-bit response beats, and presents each beat with a 1-based beat count to the downstream fetcher.
- The fetcher is the consumer of data, count and fetch_en; it splits each beat into two 32-bit instructions.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req, bus_resp and data.
- BUS_TAG_WIDTH, 13, width of Sysbus tags.
- LINE_BEATS, 8, response beats per line; count width is clog2(LINE_BEATS)+1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_start  in  1  one-cycle request to fetch a line; sampled only in IDLE.
- start_addr  in  64  byte address; its line is fetched.
- bus_reqcyc  out  1  Sysbus request valid.
- bus_req  out  BUS_DATA_WIDTH  request address, line-aligned.
- bus_reqtag  out  BUS_TAG_WIDTH  {`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00}.
- bus_reqack  in  1  Sysbus accepted the request.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  response beat data.
- bus_respack  out  1  beat accepted.
- data  out  BUS_DATA_WIDTH  registered last accepted beat.
- count  out  4  beat number 1..8 of data; 0 = no beat yet this line.
- fetch_en  out  1  one-cycle pulse: data/count updated this cycle.
- busy  out  1  high in any state except IDLE.
- line_done  out  1  one-cycle pulse on the cycle beat 8 is presented.

Behaviour:
- Reset, asynchronous, any state:
  - State goes to IDLE.
  - bus_reqcyc, bus_respack, fetch_en, line_done and busy go to 0 immediately.
  - data=0, count=0, beat counter=0, captured address=0.
  - Any in-flight bus transaction is abandoned; late response beats arriving in IDLE are not acked.
- States: IDLE, REQ, RESP.
- IDLE:
  - If fetch_start=1 at a clock edge: capture start_addr with bits [5:0] cleared, set count=0, go to REQ.
  - Otherwise stay.
- REQ:
  - bus_reqcyc=1.
  - bus_req = captured address; bus_reqtag per port list. Both are held stable while bus_reqcyc=1.
  - Stay until bus_reqack=1 is sampled at an edge, then go to RESP.
  - bus_reqcyc is 0 from the next cycle.
  - Minimum 1 cycle in REQ. bus_reqack while not in REQ is ignored.
- RESP:
  - bus_respack = bus_respcyc (combinational); bus_respack=0 outside RESP.
  - On each edge with bus_respcyc=1:
    - data <= bus_resp.
    - count <= beat index + 1.
    - fetch_en=1 in the following cycle.
  - Gaps (bus_respcyc=0) are allowed: fetch_en=0 during a gap, and data and count hold their values.
  - Beats arrive in order; bus_resptag is not checked.
  - After the 8th accepted beat: line_done=1 and fetch_en=1 in the same cycle as count=8; state returns to IDLE.
- Latency:
  - fetch_start to bus_reqcyc: 1 cycle.
  - bus_respcyc beat to data/fetch_en: 1 cycle.
- Busy rules:
  - fetch_start during REQ or RESP is ignored; it is not queued.
  - fetch_start in the same cycle the FSM returns to IDLE (the line_done cycle) is accepted.
- count stays at 8 after a line completes, until the next fetch_start clears it to 0.
- Beat counter wraps only through the IDLE transition; a 9th bus_respcyc is never acked.

Test Plan:
- Basic line:
  - Stimulus: reset_n low then high; fetch_start with start_addr=0x1000_0044; bus_reqack after 2 cycles; 8 back-to-back beats 0x11..0x88.
  - Response: bus_req=0x1000_0040 with bus_reqtag READ/MEMORY; count steps 1..8 with data 0x11..0x88; 8 fetch_en pulses; line_done coincides with count=8; busy=0 after.
- Gapped response:
  - Stimulus: beats 3 and 6 each preceded by a 2-cycle bus_respcyc=0 gap.
  - Response: fetch_en low in gaps; count holds 2 and 5 during gaps; bus_respack mirrors bus_respcyc; total 8 pulses.
- Delayed ack:
  - Stimulus: bus_reqack held low for 5 cycles, with the bus_req address checked each cycle.
  - Response: bus_reqcyc stays 1 with a stable address for 6 cycles and drops the cycle after the ack.
- Busy collision:
  - Stimulus: fetch_start with addr 0x2000 issued during RESP, then fetch_start in the line_done cycle with addr 0x3008.
  - Response: the first is ignored; the second produces bus_req=0x3000 one cycle later.
- Mid-line reset:
  - Stimulus: assert reset_n low asynchronously between edges after beat 4.
  - Response: all outputs 0 immediately; subsequent bus_respcyc not acked; fetch_en stays 0.
- Stray response:
  - Stimulus: bus_respcyc=1 while in IDLE.
  - Response: bus_respack=0, no fetch_en, count unchanged.
